// File: rtl/ramp_generator_pkg.sv
// Shared types and constants for the single-slope ramp sequencer (package ramp_pkg).
package ramp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    RAMP  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_STEP_WIDTH    = 4;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Full-scale DAC code for a given code width (2^width - 1).
  function automatic logic [31:0] max_code(input int unsigned width);
    max_code = (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/ramp_generator_if.sv
// Conversion control and ramp outputs between the sequencer (slave) and its controller (master).
interface ramp_generator_if
  import ramp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH
) ();

  logic                  start;
  logic [STEP_WIDTH-1:0] step;
  logic                  comp_out;
  logic [WIDTH-1:0]      dac_code;
  logic                  sh_en;
  logic                  ramp_sync;
  logic                  busy;
  logic                  done;

  modport master (
    output start, step, comp_out,
    input  dac_code, sh_en, ramp_sync, busy, done
  );

  modport slave (
    input  start, step, comp_out,
    output dac_code, sh_en, ramp_sync, busy, done
  );

endinterface

// File: rtl/ramp_generator_sync_2ff.sv
// Two-flop synchronizer for the asynchronous comparator output; async active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Metastability chain: raw input is visible at q two edges after it changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ramp_generator.sv
// Reference-ramp sequencer: IDLE -> TRACK (sample-and-hold) -> RAMP (DAC steps) -> DONE.
// Optional comparator early stop is compiled in with `define RAMP_EARLY_STOP_EN.
module ramp_generator
  import ramp_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STEP_WIDTH    = DEF_STEP_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic             clk,
  input logic             rst,
  ramp_generator_if.slave bus
);

  localparam int SUM_W = WIDTH + 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SUM_W-1:0]      MAX_SUM     = SUM_W'(max_code(WIDTH));
  localparam logic [WIDTH-1:0]      MAX_DAC     = WIDTH'(max_code(WIDTH));
  localparam logic [WIDTH-1:0]      ZERO_DAC    = {WIDTH{1'b0}};
  localparam logic [STEP_WIDTH-1:0] ZERO_STEP   = {STEP_WIDTH{1'b0}};
  localparam logic [STEP_WIDTH-1:0] ONE_STEP    = STEP_WIDTH'(1);
  localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      ZERO_CNT    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      ONE_CNT     = CNT_W'(1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      dac_code_q, dac_code_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sh_en_q, sh_en_d;
  logic                  ramp_sync_q, ramp_sync_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [SUM_W-1:0]      sum_s;
  logic                  early_stop_s;

`ifdef RAMP_EARLY_STOP_EN
  logic comp_sync_s;
  logic comp_prev_q, comp_prev_d;

  sync_2ff u_comp_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.comp_out),
    .q   (comp_sync_s)
  );

  assign comp_prev_d = comp_sync_s;

  // Previous synchronized comparator level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_prev_q <= 1'b0;
    end else begin
      comp_prev_q <= comp_prev_d;
    end
  end

  assign early_stop_s = comp_sync_s & ~comp_prev_q;
`else
  assign early_stop_s = 1'b0;
`endif

  // Compare in WIDTH+1 bits so an overshooting step saturates instead of wrapping.
  assign sum_s = {1'b0, dac_code_q} + SUM_W'(step_q);

  // Next-state and next-output logic; outputs are derived from the next state so they stay registered.
  always_comb begin
    state_d     = state_q;
    dac_code_d  = dac_code_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    ramp_sync_d = 1'b0;
    case (state_q)
      IDLE: begin
        dac_code_d = ZERO_DAC;
        if (bus.start) begin
          state_d = TRACK;
          step_d  = (bus.step == ZERO_STEP) ? ONE_STEP : bus.step;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      TRACK: begin
        dac_code_d = ZERO_DAC;
        if (cnt_q == ZERO_CNT) begin
          state_d     = RAMP;
          ramp_sync_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE_CNT;
        end
      end
      RAMP: begin
        if (early_stop_s || (dac_code_q == MAX_DAC)) begin
          state_d    = DONE;
          dac_code_d = ZERO_DAC;
        end else if (sum_s > MAX_SUM) begin
          dac_code_d = MAX_DAC;
        end else begin
          dac_code_d = sum_s[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d    = IDLE;
        dac_code_d = ZERO_DAC;
      end
      default: begin
        state_d    = IDLE;
        dac_code_d = ZERO_DAC;
      end
    endcase
    sh_en_d = (state_d == TRACK);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dac_code_q  <= ZERO_DAC;
      step_q      <= ZERO_STEP;
      cnt_q       <= ZERO_CNT;
      sh_en_q     <= 1'b0;
      ramp_sync_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dac_code_q  <= dac_code_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      sh_en_q     <= sh_en_d;
      ramp_sync_q <= ramp_sync_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.dac_code  = dac_code_q;
  assign bus.sh_en     = sh_en_q;
  assign bus.ramp_sync = ramp_sync_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
